// File: rtl/vthernet_pkg.sv
// Shared Ethernet/ARP constants, the rx_arp state encoding and the ARP header byte check.
package vthernet_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
  localparam logic [15:0] ETHERTYPE_IPV4   = 16'h0800;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY   = 16'h0002;
  localparam logic [7:0]  ARP_HLEN_ETH     = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4    = 8'd4;
  localparam int          ARP_LEN          = 28;

  typedef enum logic [2:0] {
    ST_SKIP,
    ST_HDR,
    ST_SHA,
    ST_SPA,
    ST_THA,
    ST_TPA,
    ST_TAIL
  } rx_arp_state_t;

  // 16-bit fields are judged on their second byte, so hi is the byte received just before b.
  function automatic logic hdr_byte_ok(input logic [4:0] idx, input logic [7:0] hi,
                                       input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    case (idx)
      5'd0, 5'd2, 5'd6: ok = 1'b1;
      5'd1:             ok = ({hi, b} == ARP_HTYPE_ETH);
      5'd3:             ok = ({hi, b} == ETHERTYPE_IPV4);
      5'd4:             ok = (b == ARP_HLEN_ETH);
      5'd5:             ok = (b == ARP_PLEN_IPV4);
      5'd7:             ok = ({hi, b} == ARP_OPER_REQUEST) || ({hi, b} == ARP_OPER_REPLY);
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that sticks at 16'hFFFF; synchronous active-high reset.
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 16'h0000;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'h0001;
    end
  end

endmodule

// File: rtl/rx_arp.sv
// ARP payload parser: validates the header, captures sender fields, and holds a result
// when the target IP matches LOCAL_IP. Define RX_ARP_STATS_EN to add drop/error counters.
module rx_arp
  import vthernet_pkg::*;
#(
  parameter logic [31:0] LOCAL_IP = 32'hC0A8_000A
) (
  input  logic        RX_CLK,
  input  logic        rst,
  input  logic        rx_payload_arp,
  input  logic [7:0]  rx_payload,
  input  logic        arp_ready,
  output logic        arp_valid,
  output logic [15:0] arp_oper,
  output logic [47:0] arp_sha,
  output logic [31:0] arp_spa,
  output logic        arp_err
`ifdef RX_ARP_STATS_EN
  ,
  output logic [15:0] arp_drop_cnt,
  output logic [15:0] arp_err_cnt
`endif
);

  localparam logic [4:0] IDX_SAT = 5'(ARP_LEN);

  rx_arp_state_t state, state_nxt;
  logic [4:0]  idx;
  logic [7:0]  prev_byte;
  logic [15:0] oper_r;
  logic [47:0] sha_r;
  logic [31:0] spa_r;
  logic [23:0] tpa_r;
  logic        err_nxt;
  logic        match;
  logic        load;

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    match     = 1'b0;
    case (state)
      ST_SKIP: begin
        if (!rx_payload_arp) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        if (rx_payload_arp) begin
          if (!hdr_byte_ok(idx, prev_byte, rx_payload)) begin
            err_nxt   = 1'b1;
            state_nxt = ST_SKIP;
          end else if (idx == 5'd7) begin
            state_nxt = ST_SHA;
          end
        end else if (idx != 5'd0) begin
          err_nxt = 1'b1;
        end
      end
      ST_SHA, ST_SPA, ST_THA, ST_TPA: begin
        if (!rx_payload_arp) begin
          err_nxt   = 1'b1;
          state_nxt = ST_HDR;
        end else if (state == ST_SHA && idx == 5'd13) begin
          state_nxt = ST_SPA;
        end else if (state == ST_SPA && idx == 5'd17) begin
          state_nxt = ST_THA;
        end else if (state == ST_THA && idx == 5'd23) begin
          state_nxt = ST_TPA;
        end else if (state == ST_TPA && idx == 5'd27) begin
          state_nxt = ST_TAIL;
          match     = ({tpa_r, rx_payload} == LOCAL_IP);
        end
      end
      ST_TAIL: begin
        if (!rx_payload_arp) state_nxt = ST_HDR;
      end
      default: state_nxt = ST_SKIP;
    endcase
  end

  // A held result that is not being consumed this cycle blocks a new one.
  assign load = match && (!arp_valid || arp_ready);

  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      state     <= ST_SKIP;
      idx       <= 5'd0;
      arp_err   <= 1'b0;
      arp_valid <= 1'b0;
      arp_oper  <= 16'h0000;
      arp_sha   <= 48'h0;
      arp_spa   <= 32'h0;
    end else begin
      state   <= state_nxt;
      arp_err <= err_nxt;
      if (!rx_payload_arp)    idx <= 5'd0;
      else if (idx != IDX_SAT) idx <= idx + 5'd1;
      if (load) begin
        arp_valid <= 1'b1;
        arp_oper  <= oper_r;
        arp_sha   <= sha_r;
        arp_spa   <= spa_r;
      end else if (arp_valid && arp_ready) begin
        arp_valid <= 1'b0;
      end
    end
  end

  // Field shift registers carry no reset; they are always rewritten before being loaded.
  always_ff @(posedge RX_CLK) begin
    if (rx_payload_arp) begin
      case (state)
        ST_HDR: begin
          prev_byte <= rx_payload;
          if (idx == 5'd7) oper_r <= {prev_byte, rx_payload};
        end
        ST_SHA:  sha_r <= {sha_r[39:0], rx_payload};
        ST_SPA:  spa_r <= {spa_r[23:0], rx_payload};
        ST_TPA:  tpa_r <= {tpa_r[15:0], rx_payload};
        default: ;
      endcase
    end
  end

`ifdef RX_ARP_STATS_EN
  logic drop;
  assign drop = match && arp_valid && !arp_ready;

  sat_cnt16 u_drop_cnt (
    .clk   (RX_CLK),
    .rst   (rst),
    .inc   (drop),
    .count (arp_drop_cnt)
  );

  sat_cnt16 u_err_cnt (
    .clk   (RX_CLK),
    .rst   (rst),
    .inc   (arp_err),
    .count (arp_err_cnt)
  );
`endif

endmodule

// File: tb/tb_rx_arp.sv
// Self-checking bench for rx_arp: scoreboard of expected ARP results plus per-scenario checks.
module tb_rx_arp;

  localparam logic [31:0] LIP = 32'hC0A8000A;

  logic        RX_CLK = 1'b0;
  logic        rst = 1'b1;
  logic        strobe = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        ready = 1'b0;
  logic        arp_valid;
  logic [15:0] arp_oper;
  logic [47:0] arp_sha;
  logic [31:0] arp_spa;
  logic        arp_err;
`ifdef RX_ARP_STATS_EN
  logic [15:0] arp_drop_cnt;
  logic [15:0] arp_err_cnt;
`endif

  rx_arp #(.LOCAL_IP(LIP)) dut (
    .RX_CLK         (RX_CLK),
    .rst            (rst),
    .rx_payload_arp (strobe),
    .rx_payload     (data),
    .arp_ready      (ready),
    .arp_valid      (arp_valid),
    .arp_oper       (arp_oper),
    .arp_sha        (arp_sha),
    .arp_spa        (arp_spa),
    .arp_err        (arp_err)
`ifdef RX_ARP_STATS_EN
    ,
    .arp_drop_cnt   (arp_drop_cnt),
    .arp_err_cnt    (arp_err_cnt)
`endif
  );

  always #4 RX_CLK = ~RX_CLK;

  typedef struct packed {
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
  } res_t;

  res_t       exp_q[$];
  logic [7:0] pkt [0:63];
  int         byte_cyc [0:63];
  int checks = 0, failures = 0, cyc = 0;
  int err_seen = 0, last_err_cyc = -1, valid_first_cyc = -1, valid_rises = 0;
  int exp_errs = 0, exp_drops = 0;
  bit prev_valid = 1'b0;

  always @(posedge RX_CLK) cyc++;

  // Monitor: count error pulses and result rises, and score every accepted result.
  always @(negedge RX_CLK) begin
    if (arp_err) begin
      err_seen++;
      last_err_cyc = cyc;
    end
    if (arp_valid && !prev_valid) begin
      valid_rises++;
      valid_first_cyc = cyc;
    end
    prev_valid = arp_valid;
    if (arp_valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_unexpected got sha=%h spa=%h oper=%h want none", arp_sha, arp_spa, arp_oper);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        if ({arp_oper, arp_sha, arp_spa} !== e) begin
          failures++;
          $display("FAIL scoreboard_result got oper=%h sha=%h spa=%h want oper=%h sha=%h spa=%h",
                   arp_oper, arp_sha, arp_spa, e.oper, e.sha, e.spa);
        end
      end
    end
  end

  task automatic build(input logic [15:0] oper, input logic [47:0] sha, input logic [31:0] spa,
                       input logic [31:0] tpa);
    logic [63:0] hdr;
    hdr = {16'h0001, 16'h0800, 8'd6, 8'd4, oper};
    for (int k = 0; k < 8; k++) pkt[k] = hdr[63-8*k -: 8];
    for (int k = 0; k < 6; k++) pkt[8+k] = sha[47-8*k -: 8];
    for (int k = 0; k < 4; k++) pkt[14+k] = spa[31-8*k -: 8];
    for (int k = 0; k < 6; k++) pkt[18+k] = 8'hA0 + 8'(k);
    for (int k = 0; k < 4; k++) pkt[24+k] = tpa[31-8*k -: 8];
    for (int k = 28; k < 64; k++) pkt[k] = 8'h00;
  endtask

  task automatic drive_burst(input int n, input int rst_idx, input bit ready_last);
    for (int i = 0; i < n; i++) begin
      @(posedge RX_CLK); #1;
      rst    = (i == rst_idx);
      strobe = 1'b1;
      data   = pkt[i];
      byte_cyc[i] = cyc;
      if (ready_last && i == n - 1) ready = 1'b1;
    end
    @(posedge RX_CLK); #1;
    rst    = 1'b0;
    strobe = 1'b0;
    data   = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge RX_CLK); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; strobe = 1'b0; ready = 1'b0;
    repeat (3) @(posedge RX_CLK);
    #1 rst = 1'b0;
    @(negedge RX_CLK);
    checks += 5;
    if (arp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", arp_valid); end
    if (arp_err !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", arp_err); end
    if (arp_oper !== 16'h0) begin failures++; $display("FAIL reset_oper got %h want 0", arp_oper); end
    if (arp_sha !== 48'h0) begin failures++; $display("FAIL reset_sha got %h want 0", arp_sha); end
    if (arp_spa !== 32'h0) begin failures++; $display("FAIL reset_spa got %h want 0", arp_spa); end
`ifdef RX_ARP_STATS_EN
    checks += 2;
    if (arp_drop_cnt !== 16'h0) begin failures++; $display("FAIL reset_drop_cnt got %0d want 0", arp_drop_cnt); end
    if (arp_err_cnt !== 16'h0) begin failures++; $display("FAIL reset_err_cnt got %0d want 0", arp_err_cnt); end
`endif
    idle(2);
  endtask

  task automatic test_request_match();
    int e0;
    ready = 1'b1;
    e0 = err_seen;
    build(16'd1, 48'h020000000001, 32'hC0A80001, LIP);
    exp_q.push_back({16'd1, 48'h020000000001, 32'hC0A80001});
    drive_burst(28, -1, 1'b0);
    @(negedge RX_CLK);
    checks += 4;
    if (arp_valid !== 1'b1) begin failures++; $display("FAIL match_valid got %b want 1", arp_valid); end
    if (arp_sha !== 48'h020000000001) begin failures++; $display("FAIL match_sha got %h want 020000000001", arp_sha); end
    if (arp_spa !== 32'hC0A80001) begin failures++; $display("FAIL match_spa got %h want c0a80001", arp_spa); end
    if (arp_oper !== 16'd1) begin failures++; $display("FAIL match_oper got %h want 0001", arp_oper); end
    @(negedge RX_CLK);
    checks += 3;
    if (arp_valid !== 1'b0) begin failures++; $display("FAIL match_valid_one_cycle got %b want 0", arp_valid); end
    if (valid_first_cyc !== byte_cyc[27] + 1) begin
      failures++; $display("FAIL match_latency got cycle %0d want %0d", valid_first_cyc, byte_cyc[27] + 1);
    end
    if (err_seen !== e0) begin failures++; $display("FAIL match_no_err got %0d errs want %0d", err_seen, e0); end
    idle(2);
    // Reply carrying Ethernet padding beyond byte 27.
    build(16'd2, 48'h0A1B2C3D4E5F, 32'hC0A80063, LIP);
    exp_q.push_back({16'd2, 48'h0A1B2C3D4E5F, 32'hC0A80063});
    drive_burst(46, -1, 1'b0);
    idle(2);
    checks += 3;
    if (valid_first_cyc !== byte_cyc[27] + 1) begin
      failures++; $display("FAIL padded_latency got cycle %0d want %0d", valid_first_cyc, byte_cyc[27] + 1);
    end
    if (exp_q.size() != 0) begin failures++; $display("FAIL padded_pending got %0d want 0", exp_q.size()); end
    if (err_seen !== e0) begin failures++; $display("FAIL padded_no_err got %0d errs want %0d", err_seen, e0); end
  endtask

  task automatic test_tpa_mismatch();
    int e0, v0;
    e0 = err_seen; v0 = valid_rises;
    build(16'd1, 48'h020000000001, 32'hC0A80001, 32'hC0A80063);
    drive_burst(28, -1, 1'b0);
    idle(4);
    checks += 2;
    if (valid_rises !== v0) begin failures++; $display("FAIL tpa_mismatch_valid got %0d want %0d", valid_rises, v0); end
    if (err_seen !== e0) begin failures++; $display("FAIL tpa_mismatch_err got %0d want %0d", err_seen, e0); end
  endtask

  task automatic test_bad_ptype();
    int e0, v0;
    e0 = err_seen; v0 = valid_rises;
    build(16'd1, 48'h020000000001, 32'hC0A80001, LIP);
    pkt[2] = 8'h86; pkt[3] = 8'hDD;
    drive_burst(28, -1, 1'b0);
    idle(3);
    exp_errs++;
    checks += 3;
    if (err_seen !== e0 + 1) begin failures++; $display("FAIL ptype_err_count got %0d want %0d", err_seen, e0 + 1); end
    if (last_err_cyc !== byte_cyc[3] + 1) begin
      failures++; $display("FAIL ptype_err_cycle got %0d want %0d", last_err_cyc, byte_cyc[3] + 1);
    end
    if (valid_rises !== v0) begin failures++; $display("FAIL ptype_no_valid got %0d want %0d", valid_rises, v0); end
    build(16'd1, 48'h020000000002, 32'hC0A80002, LIP);
    exp_q.push_back({16'd1, 48'h020000000002, 32'hC0A80002});
    drive_burst(28, -1, 1'b0);
    idle(3);
    checks += 2;
    if (valid_rises !== v0 + 1) begin failures++; $display("FAIL ptype_recover got %0d want %0d", valid_rises, v0 + 1); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL ptype_recover_pending got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_short();
    int e0, v0;
    e0 = err_seen; v0 = valid_rises;
    build(16'd1, 48'h020000000001, 32'hC0A80001, LIP);
    drive_burst(20, -1, 1'b0);
    idle(3);
    exp_errs++;
    checks += 3;
    if (err_seen !== e0 + 1) begin failures++; $display("FAIL short_err_count got %0d want %0d", err_seen, e0 + 1); end
    if (last_err_cyc !== byte_cyc[19] + 2) begin
      failures++; $display("FAIL short_err_cycle got %0d want %0d", last_err_cyc, byte_cyc[19] + 2);
    end
    if (valid_rises !== v0) begin failures++; $display("FAIL short_no_valid got %0d want %0d", valid_rises, v0); end
`ifdef RX_ARP_STATS_EN
    checks++;
    if (arp_err_cnt !== 16'(exp_errs)) begin failures++; $display("FAIL short_err_cnt got %0d want %0d", arp_err_cnt, exp_errs); end
`endif
  endtask

  task automatic test_back_to_back();
    ready = 1'b0;
    build(16'd1, 48'h020000000011, 32'hC0A80011, LIP);
    exp_q.push_back({16'd1, 48'h020000000011, 32'hC0A80011});
    drive_burst(28, -1, 1'b0);
    idle(2);
    build(16'd2, 48'h020000000022, 32'hC0A80022, LIP);
    drive_burst(28, -1, 1'b0);
    idle(2);
    exp_drops++;
    @(negedge RX_CLK);
    checks += 3;
    if (arp_valid !== 1'b1) begin failures++; $display("FAIL hold_valid got %b want 1", arp_valid); end
    if (arp_sha !== 48'h020000000011) begin failures++; $display("FAIL hold_sha got %h want 020000000011", arp_sha); end
    if (arp_spa !== 32'hC0A80011) begin failures++; $display("FAIL hold_spa got %h want c0a80011", arp_spa); end
`ifdef RX_ARP_STATS_EN
    checks++;
    if (arp_drop_cnt !== 16'(exp_drops)) begin failures++; $display("FAIL hold_drop_cnt got %0d want %0d", arp_drop_cnt, exp_drops); end
`endif
    build(16'd1, 48'h020000000033, 32'hC0A80033, LIP);
    exp_q.push_back({16'd1, 48'h020000000033, 32'hC0A80033});
    drive_burst(28, -1, 1'b1);
    @(negedge RX_CLK);
    checks += 2;
    if (arp_valid !== 1'b1) begin failures++; $display("FAIL reload_valid got %b want 1", arp_valid); end
    if (arp_sha !== 48'h020000000033) begin failures++; $display("FAIL reload_sha got %h want 020000000033", arp_sha); end
    @(negedge RX_CLK);
    checks += 2;
    if (arp_valid !== 1'b0) begin failures++; $display("FAIL reload_cleared got %b want 0", arp_valid); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL reload_pending got %0d want 0", exp_q.size()); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    int e0, v0;
    ready = 1'b0;
    build(16'd1, 48'h020000000044, 32'hC0A80044, LIP);
    drive_burst(28, -1, 1'b0);
    idle(2);
    e0 = err_seen; v0 = valid_rises;
    build(16'd1, 48'h020000000055, 32'hC0A80055, LIP);
    drive_burst(28, 12, 1'b0);
    idle(2);
    @(negedge RX_CLK);
    exp_errs = 0; exp_drops = 0;
    checks += 6;
    if (arp_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got %b want 0", arp_valid); end
    if (arp_oper !== 16'h0) begin failures++; $display("FAIL midrst_oper got %h want 0", arp_oper); end
    if (arp_sha !== 48'h0) begin failures++; $display("FAIL midrst_sha got %h want 0", arp_sha); end
    if (arp_spa !== 32'h0) begin failures++; $display("FAIL midrst_spa got %h want 0", arp_spa); end
    if (err_seen !== e0) begin failures++; $display("FAIL midrst_no_err got %0d want %0d", err_seen, e0); end
    if (valid_rises !== v0) begin failures++; $display("FAIL midrst_no_valid got %0d want %0d", valid_rises, v0); end
`ifdef RX_ARP_STATS_EN
    checks += 2;
    if (arp_drop_cnt !== 16'(exp_drops)) begin failures++; $display("FAIL midrst_drop_cnt got %0d want 0", arp_drop_cnt); end
    if (arp_err_cnt !== 16'(exp_errs)) begin failures++; $display("FAIL midrst_err_cnt got %0d want 0", arp_err_cnt); end
`endif
    ready = 1'b1;
    build(16'd2, 48'h020000000066, 32'hC0A80066, LIP);
    exp_q.push_back({16'd2, 48'h020000000066, 32'hC0A80066});
    drive_burst(28, -1, 1'b0);
    idle(3);
    checks += 2;
    if (valid_rises !== v0 + 1) begin failures++; $display("FAIL midrst_recover got %0d want %0d", valid_rises, v0 + 1); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL midrst_pending got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_request_match();
    test_tpa_mismatch();
    test_bad_ptype();
    test_short();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL final_pending got %0d want 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_arp.md
RX_ARP -- requirements
Module: rx_arp

Interface
REQ-001 Parameter LOCAL_IP, default 32'hC0A8_000A (192.168.0.10): IPv4 address this node answers to.
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 RX_CLK  in  1  GMII receive clock; every register updates on its rising edge.
REQ-004 rst  in  1  reset, sampled on RX_CLK.
REQ-005 rx_payload_arp  in  1  byte strobe from the upstream MAC receive stage; high for each ARP payload byte; low marks the frame boundary.
REQ-006 rx_payload  in  8  payload byte, valid when rx_payload_arp is high.
REQ-007 arp_ready  in  1  consumer accepts the held result.
REQ-008 arp_valid  out  1  result held on arp_oper, arp_sha and arp_spa.
REQ-009 arp_oper  out  16  ARP opcode: 1 = request, 2 = reply.
REQ-010 arp_sha  out  48  sender MAC address.
REQ-011 arp_spa  out  32  sender IP address.
REQ-012 arp_err  out  1  one-cycle pulse when a malformed packet is detected.

Function
REQ-013 Byte index 0-27 is counted from the first byte of each strobe burst; the counter is 5 bits and saturates at 28.
REQ-014 States: SKIP, HDR (bytes 0-7), SHA (8-13), SPA (14-17), THA (18-23), TPA (24-27), TAIL.
REQ-015 SKIP: wait until rx_payload_arp is low, then go to HDR, armed for the next burst.
REQ-016 HDR checks bytes 0-7 against HTYPE 0x0001, PTYPE 0x0800, HLEN 6, PLEN 4, and OPER 1 or 2.
REQ-017 A header mismatch pulses arp_err in the cycle after the bad byte and enters SKIP.
REQ-018 Multi-byte fields are big-endian, first byte received is the MSB; they shift into internal registers, not into the outputs.
REQ-019 THA bytes are ignored.
REQ-020 On byte 27: if TPA equals LOCAL_IP, the result is loaded into the outputs at that same clock edge, so arp_valid is high from the next cycle (latency 1).
REQ-021 On byte 27: if TPA does not equal LOCAL_IP, the packet is dropped silently with no arp_err.
REQ-022 After byte 27, enter TAIL; bytes beyond 27 (Ethernet padding) are ignored; return to HDR when rx_payload_arp falls.
REQ-023 Short packet: rx_payload_arp falls before byte 27 -> arp_err pulse, partial data discarded, go to HDR.
REQ-024 arp_valid and the output fields stay stable until a cycle with arp_valid and arp_ready both high; arp_valid clears after that cycle.
REQ-025 If a new match completes while arp_valid is high and arp_ready is low, the new result is dropped and the held result is kept.
REQ-026 If a new match completes in the same cycle arp_ready is high, the new result loads and arp_valid stays high.
REQ-027 arp_err and a result load can never coincide, because each packet ends in exactly one outcome.

Reset
REQ-028 On reset, arp_valid = 0, arp_err = 0, arp_oper = 0, arp_sha = 0, arp_spa = 0, the counters are 0, and the state is SKIP.
REQ-029 Reset mid-packet discards the packet; the remainder of the burst is ignored via SKIP.
REQ-030 Reset overrides arp_ready and any in-flight byte.

Configuration
REQ-031 Macro RX_ARP_STATS_EN, when defined, adds the outputs arp_drop_cnt (16 bits, counts REQ-025 drops) and arp_err_cnt (16 bits, counts arp_err pulses).
REQ-032 Both counters saturate at 16'hFFFF and reset to 0.
REQ-033 Without RX_ARP_STATS_EN, these ports and counters do not exist, and all other behaviour is identical.

Structure
REQ-034 Package vthernet_pkg holds ARP_HTYPE_ETH, ETHERTYPE_IPV4, ARP_OPER_REQUEST, ARP_OPER_REPLY, ARP_LEN = 28 and the rx_arp state encoding.
REQ-035 One sub-module, sat_cnt16 (a saturating 16-bit counter with increment and reset), is instantiated twice under RX_ARP_STATS_EN.

Verification
REQ-036 A valid request (OPER 1, SHA 02:00:00:00:00:01, SPA 192.168.0.1, TPA 192.168.0.10) with arp_ready = 1 -> arp_valid for 1 cycle, one cycle after byte 27, arp_sha = 48'h020000000001, arp_spa = 32'hC0A80001.
REQ-037 Same request with TPA 192.168.0.99 -> no arp_valid and no arp_err.
REQ-038 PTYPE 0x86DD -> arp_err pulse one cycle after byte 3; later bytes are ignored; the next valid packet parses normally.
REQ-039 Burst of 20 bytes -> arp_err pulse; arp_err_cnt = 1 (STATS_EN).
REQ-040 Two matching packets with arp_ready = 0 -> the first result is held and arp_drop_cnt = 1; arp_ready asserted in the same cycle a third match completes -> the third loads and arp_valid stays high.
REQ-041 rst pulsed at byte 12 with the strobe still high -> outputs are 0 and no result; the next burst parses correctly.
